// File: rtl/floo_hbm_req_scheduler.sv
// Round-robin request scheduler that shares one HBM channel among NumReq sources,
// with per-requester outstanding caps and a flush/drain handshake.
// Optional statistics outputs are enabled with FLOO_HBM_SCHED_STATS_EN.
module floo_hbm_req_scheduler #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned LenWidth       = 8,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
    parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*LenWidth-1:0]    req_len_i,
    input  logic [NumReq-1:0]             req_write_i,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [LenWidth-1:0]           mem_len_o,
    output logic                          mem_write_o,
    output logic [IdxWidth-1:0]           mem_src_o,
    input  logic                          cpl_valid_i,
    input  logic [IdxWidth-1:0]           cpl_src_i,
    input  logic                          flush_i,
    output logic                          flush_done_o,
    output logic [NumReq*CntWidth-1:0]    outstanding_o,
`ifdef FLOO_HBM_SCHED_STATS_EN
    output logic [31:0]                   stall_cycles_o,
    output logic [NumReq*32-1:0]          grant_cnt_o,
`endif
    output logic                          err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Handshakes: req_* and mem_* follow valid/ready; a transfer happens in the
    // cycle where both are high, and mem_* payload holds while valid waits for ready.
    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic                  write_q, write_d;
    logic [IdxWidth-1:0]   src_q, src_d;
    logic [IdxWidth-1:0]   ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic [CntWidth-1:0]   cnt_q [NumReq];
    logic [CntWidth-1:0]   cnt_d [NumReq];

    logic [NumReq-1:0]     eligible;
    logic                  gnt_found;
    logic [IdxWidth-1:0]   gnt_idx;
    logic                  issue_hs;
    logic                  all_zero;

    always_comb begin
        eligible  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        all_zero  = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
            if (cnt_q[i] != '0) all_zero = 1'b0;
        end
        // Scan cyclically starting at the pointer; first eligible wins.
        for (int k = 0; k < NumReq; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= int'(NumReq)) j = j - int'(NumReq);
            if (!gnt_found && eligible[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxWidth'(j);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        len_d        = len_q;
        write_d      = write_q;
        src_d        = src_q;
        ptr_d        = ptr_q;
        req_ready_o  = '0;
        flush_done_o = 1'b0;
        issue_hs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end else if (gnt_found) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    addr_d  = req_addr_i[int'(gnt_idx)*AddrWidth +: AddrWidth];
                    len_d   = req_len_i[int'(gnt_idx)*LenWidth +: LenWidth];
                    write_d = req_write_i[gnt_idx];
                    src_d   = gnt_idx;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    issue_hs = 1'b1;
                    valid_d  = 1'b0;
                    ptr_d    = (int'(src_q) == int'(NumReq) - 1) ? '0 : src_q + 1'b1;
                    state_d  = flush_i ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (all_zero) begin
                    flush_done_o = 1'b1;
                    state_d      = flush_i ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!flush_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        logic src_hit;
        logic src_zero;
        src_hit  = 1'b0;
        src_zero = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            logic inc;
            logic dec;
            inc = issue_hs && (src_q == IdxWidth'(i));
            dec = cpl_valid_i && (cpl_src_i == IdxWidth'(i)) && (cnt_q[i] != '0);
            if (cpl_src_i == IdxWidth'(i)) begin
                src_hit  = 1'b1;
                src_zero = (cnt_q[i] == '0);
            end
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) cnt_d[i] = cnt_q[i] + 1'b1;
            if (dec && !inc) cnt_d[i] = cnt_q[i] - 1'b1;
            outstanding_o[i*CntWidth +: CntWidth] = cnt_q[i];
        end
        err_d = err_q | (cpl_valid_i && (!src_hit || src_zero));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            write_q <= 1'b0;
            src_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            write_q <= write_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_len_o   = len_q;
    assign mem_write_o = write_q;
    assign mem_src_o   = src_q;
    assign err_o       = err_q;

`ifdef FLOO_HBM_SCHED_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] gcnt_q [NumReq];
    logic [31:0] gcnt_d [NumReq];

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !mem_ready_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
        for (int i = 0; i < NumReq; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (issue_hs && (src_q == IdxWidth'(i))) gcnt_d[i] = gcnt_q[i] + 32'd1;
            grant_cnt_o[i*32 +: 32] = gcnt_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            for (int i = 0; i < NumReq; i++) gcnt_q[i] <= '0;
        end else begin
            stall_q <= stall_d;
            for (int i = 0; i < NumReq; i++) gcnt_q[i] <= gcnt_d[i];
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_floo_hbm_req_scheduler.sv
// Self-checking bench for floo_hbm_req_scheduler: per-cycle vector table plus
// hand-written corner sequences, with a queue of expected memory requests.
module tb_floo_hbm_req_scheduler;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int LW = 8;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int BW = AW + LW + 1 + IW;

  typedef struct {
    logic [N-1:0]  valid;
    logic          mem_rdy;
    logic          cpl_v;
    logic [IW-1:0] cpl_src;
    logic          flush;
    logic [N-1:0]  exp_ready;
    logic          exp_mval;
    logic          exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] req_valid_i = '0;
  logic [N-1:0] req_ready_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*LW-1:0] req_len_i;
  logic [N-1:0] req_write_i;
  logic mem_valid_o;
  logic mem_ready_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_len_o;
  logic mem_write_o;
  logic [IW-1:0] mem_src_o;
  logic cpl_valid_i = 1'b0;
  logic [IW-1:0] cpl_src_i = '0;
  logic flush_i = 1'b0;
  logic flush_done_o;
  logic [N*CW-1:0] outstanding_o;
  logic err_o;
`ifdef FLOO_HBM_SCHED_STATS_EN
  logic [31:0] stall_cycles_o;
  logic [N*32-1:0] grant_cnt_o;
`endif

  logic [AW-1:0] addr_v [N];
  logic [LW-1:0] len_v [N];
  logic          wr_v [N];

  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[$];

  floo_hbm_req_scheduler dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_write_i(req_write_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_len_o(mem_len_o),
    .mem_write_o(mem_write_o), .mem_src_o(mem_src_o),
    .cpl_valid_i(cpl_valid_i), .cpl_src_i(cpl_src_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .outstanding_o(outstanding_o),
`ifdef FLOO_HBM_SCHED_STATS_EN
    .stall_cycles_o(stall_cycles_o), .grant_cnt_o(grant_cnt_o),
`endif
    .err_o(err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    req_addr_i  = '0;
    req_len_i   = '0;
    req_write_i = '0;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*AW +: AW] = addr_v[i];
      req_len_i[i*LW +: LW]  = len_v[i];
      req_write_i[i]         = wr_v[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_payload(input int i);
    addr_v[i] = {16'($urandom_range(0, 16'hffff)), $urandom()};
    len_v[i]  = 8'($urandom_range(0, 255));
    wr_v[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0; mem_ready_i = 1'b0; cpl_valid_i = 1'b0;
    cpl_src_i = '0; flush_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic r, input logic cv,
                              input logic [IW-1:0] cs, input logic f,
                              input logic [N-1:0] er, input logic em, input logic ed);
    vec_t t;
    t.valid = v; t.mem_rdy = r; t.cpl_v = cv; t.cpl_src = cs; t.flush = f;
    t.exp_ready = er; t.exp_mval = em; t.exp_done = ed;
    return t;
  endfunction

  // driver: one clock cycle from posedge+1 to the next posedge+1
  task automatic cycle(input vec_t t);
    int gi;
    gi = -1;
    req_valid_i = t.valid; mem_ready_i = t.mem_rdy;
    cpl_valid_i = t.cpl_v; cpl_src_i = t.cpl_src; flush_i = t.flush;
    @(negedge clk);
    check("req_ready", 64'(req_ready_o), 64'(t.exp_ready));
    check("mem_valid", 64'(mem_valid_o), 64'(t.exp_mval));
    check("flush_done", 64'(flush_done_o), 64'(t.exp_done));
    for (int i = 0; i < N; i++) if (t.exp_ready[i]) gi = i;
    if (gi >= 0) exp_q.push_back({addr_v[gi], len_v[gi], wr_v[gi], IW'(gi)});
    @(posedge clk);
    #1;
    if (gi >= 0) new_payload(gi);
  endtask

  // scoreboard: every memory handshake must match the oldest expected request
  always @(negedge clk) begin
    if (!rst_i && mem_valid_o && mem_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_issue", 64'(mem_src_o), 64'hffff);
      end else begin
        check("sb_mem_req", 64'({mem_addr_o, mem_len_o, mem_write_o, mem_src_o}),
              64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [BW-1:0] saved;
    for (int i = 0; i < N; i++) new_payload(i);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_flush_done", 64'(flush_done_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_mem_payload", 64'({mem_addr_o, mem_len_o, mem_write_o, mem_src_o}), 64'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // single request, 1-cycle latency to mem_valid
    addr_v[0] = 48'h1000; len_v[0] = 8'd3; wr_v[0] = 1'b0;
    cycle(mk(4'b0001, 1, 0, 0, 0, 4'b0001, 0, 0));
    cycle(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    check("single_addr", 64'(mem_addr_o), 64'h1000);
    check("single_len", 64'(mem_len_o), 64'd3);
    check("single_cnt0", 64'(outstanding_o[0 +: CW]), 64'd1);
    check("single_mval_drop", 64'(mem_valid_o), 64'd0);

    // fairness table: all valid, memory always ready, cap at 8 each
    do_reset();
    tbl.delete();
    for (int k = 0; k < 32; k++) begin
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'(1 << (k % 4)), 0, 0));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000, 1, 0));
    end
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000, 0, 0));
    foreach (tbl[i]) cycle(tbl[i]);
    check("fair_caps", 64'(outstanding_o), 64'h8888);

    // flush table: three outstanding, drain, DONE, resume
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0100, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 1, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 1, 1, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 1, 2, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0111, 1, 0, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    foreach (tbl[i]) cycle(tbl[i]);
    check("flush_resume_cnt", 64'(outstanding_o), 64'h0001);
    check("flush_err", 64'(err_o), 64'd0);

    // backpressure: payload stable for 5 stalled cycles
    do_reset();
    saved = {addr_v[3], len_v[3], wr_v[3], 2'd3};
    cycle(mk(4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0));
    for (int s = 0; s < 5; s++) begin
      cycle(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0));
      check("bp_stable", 64'({mem_addr_o, mem_len_o, mem_write_o, mem_src_o}), 64'(saved));
      check("bp_cnt_hold", 64'(outstanding_o[3*CW +: CW]), 64'd0);
    end
    cycle(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    check("bp_cnt_inc", 64'(outstanding_o[3*CW +: CW]), 64'd1);

    // simultaneous issue and completion on requester 2
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(mk(4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0));
      cycle(mk(4'b0100, 1, 0, 0, 0, 4'b0000, 1, 0));
    end
    check("sim_pre_cnt", 64'(outstanding_o[2*CW +: CW]), 64'd3);
    cycle(mk(4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0));
    cycle(mk(4'b0000, 1, 1, 2, 0, 4'b0000, 1, 0));
    check("sim_cnt", 64'(outstanding_o[2*CW +: CW]), 64'd3);
    check("sim_err", 64'(err_o), 64'd0);

    // error path and reset mid-ISSUE
    do_reset();
    cycle(mk(4'b0000, 0, 1, 1, 0, 4'b0000, 0, 0));
    check("err_set", 64'(err_o), 64'd1);
    check("err_cnt1", 64'(outstanding_o), 64'd0);
    repeat (3) cycle(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    check("err_sticky", 64'(err_o), 64'd1);
    cycle(mk(4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0));
    cycle(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0));
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("arst_mem_valid", 64'(mem_valid_o), 64'd0);
    check("arst_err", 64'(err_o), 64'd0);
    check("arst_payload", 64'({mem_addr_o, mem_len_o, mem_write_o, mem_src_o}), 64'd0);
    check("arst_outstanding", 64'(outstanding_o), 64'd0);
    do_reset();
    cycle(mk(4'b0010, 1, 0, 0, 0, 4'b0010, 0, 0));
    cycle(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0));
    check("post_rst_cnt", 64'(outstanding_o), 64'h0010);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/floo_hbm_req_scheduler.md
Name: floo_hbm_req_scheduler

Overview:
- Shares one HBM model channel between NumReq request sources, e.g. the narrow and wide north/south tile ports feeding a single memory.
- Issues requests with round-robin arbitration and caps outstanding transactions per requester.
- Supports a flush/drain sequence so the bench can quiesce memory traffic before end-of-simulation.

Parameters:
- NumReq, 4: number of requesters; legal range 2..16.
- AddrWidth, 48: request address width.
- LenWidth, 8: burst length field width (AXI len encoding).
- MaxOutstanding, 8: per-requester cap on issued-but-uncompleted transactions; must be at least 1.
- CntWidth, $clog2(MaxOutstanding+1): derived width of the outstanding counters.
- IdxWidth, $clog2(NumReq): derived width of the requester index.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
- req_addr_i  in  NumReq*AddrWidth  request address; slice i belongs to requester i.
- req_len_i  in  NumReq*LenWidth  request burst length; slice i belongs to requester i.
- req_write_i  in  NumReq  1 = write, 0 = read.
- mem_valid_o  out  1  registered request to the memory.
- mem_ready_i  in  1  memory accept.
- mem_addr_o  out  AddrWidth  issued address.
- mem_len_o  out  LenWidth  issued burst length.
- mem_write_o  out  1  issued direction.
- mem_src_o  out  IdxWidth  index of the requester being issued.
- cpl_valid_i  in  1  one-cycle completion pulse (last R beat or B response).
- cpl_src_i  in  IdxWidth  requester index of the completion.
- flush_i  in  1  level; request to drain.
- flush_done_o  out  1  one-cycle pulse when the drain finishes.
- outstanding_o  out  NumReq*CntWidth  current per-requester outstanding count.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; all counters = 0.
- Eligible(i) = req_valid_i[i] AND outstanding[i] < MaxOutstanding.
- FSM IDLE:
  - if flush_i = 1, go to DRAIN;
  - else, if any requester is eligible, pick the first eligible index at or after the pointer (cyclic);
  - pulse req_ready_o[i] for one cycle and capture addr/len/write/src into the output register;
  - next cycle mem_valid_o = 1 and the state is ISSUE.
  - Request-to-mem_valid latency is 1 cycle.
- FSM ISSUE:
  - mem_* held stable while mem_valid_o is high and mem_ready_i is low (AXI stability rule).
  - On mem_ready_i: increment outstanding[src]; set pointer = src+1 mod NumReq; drop mem_valid_o; return to IDLE.
  - Back-to-back grant is not allowed: a new grant occurs in the IDLE cycle that follows.
  - flush_i asserted during ISSUE does not abort the transaction; the FSM goes to DRAIN after the handshake.
- FSM DRAIN:
  - No grants; req_ready_o = 0.
  - When all outstanding counters are 0, pulse flush_done_o and go to IDLE if flush_i = 0; otherwise go to DONE.
- FSM DONE: no grants; stays until flush_i = 0, then IDLE. flush_done_o pulses exactly once per flush.
- Counters:
  - A completion decrements outstanding[cpl_src_i].
  - Issue handshake and completion on the same index in the same cycle: net count unchanged.
  - Completion on a zero counter, or cpl_src_i >= NumReq: counter unchanged and err_o set until reset.
- Starvation bound: a continuously eligible requester is granted within NumReq grants.
- Reset mid-operation: mem_valid_o drops asynchronously and all state clears; completions still in flight are then errors by design (the bench resets the models together).

Optional Feature:
- Macro FLOO_HBM_SCHED_STATS_EN.
- When defined, adds two outputs, both cleared by reset:
  - stall_cycles_o (32 bits, saturating): counts cycles with mem_valid_o=1 and mem_ready_i=0.
  - grant_cnt_o (NumReq*32 bits, wrapping): per-requester handshake counts.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Single request: req_valid_i=4'b0001, addr 0x1000, len 3; mem_ready_i=1 → mem_valid_o 1 cycle after req_ready_o[0], mem_addr_o=0x1000, mem_len_o=3, outstanding[0]=1.
- Fairness: all 4 requesters valid continuously, memory always ready, no completions → grant order 0,1,2,3,0,1,...; each requester stops at a count of 8 and no further grants occur.
- Backpressure: mem_ready_i=0 for 5 cycles after mem_valid_o → mem_* stable for all 5 cycles; the handshake on cycle 6 increments the count.
- Simultaneous events: requester 2 at count 3; issue handshake and cpl_src_i=2 in the same cycle → count stays 3, err_o=0.
- Flush: 3 transactions outstanding, assert flush_i → no grants; flush_done_o pulses once, the cycle after the 3rd completion; on flush_i release, grants resume.
- Error path: completion to requester 1 with count 0 → err_o=1 and stays 1; rst_i pulse mid-ISSUE → all outputs 0, err_o=0.
